// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants and helpers for the four-digit BCD scan counter.
package bcd_scan_counter_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int unsigned SCAN_DIV_DEFAULT = 1000;

    // One-hot digit select patterns, bit k marks digit k (0 = units).
    localparam logic [3:0] DSEL_D0 = 4'b0001;
    localparam logic [3:0] DSEL_D1 = 4'b0010;
    localparam logic [3:0] DSEL_D2 = 4'b0100;
    localparam logic [3:0] DSEL_D3 = 4'b1000;

    // Out-of-range nibbles collapse to zero so a digit never leaves 0..9.
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] n);
        return (n > BCD_MAX) ? 4'd0 : n;
    endfunction

    function automatic logic [3:0] dsel_onehot(input logic [1:0] idx);
        logic [3:0] sel;
        unique case (idx)
            2'd0:    sel = DSEL_D0;
            2'd1:    sel = DSEL_D1;
            2'd2:    sel = DSEL_D2;
            default: sel = DSEL_D3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: a registered BCD digit that steps when ci is high and
// raises co combinationally when that step rolls over (9->0 up, 0->9 down).
module bcd_digit
    import bcd_scan_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       ci,
    input  logic       up,
    output logic [3:0] q,
    output logic       co
);

    logic [3:0] r_q;
    logic [3:0] w_q_step;

    // Next value if this digit steps; rollover is flagged on co.
    always_comb begin
        w_q_step = r_q;
        if (up) begin
            w_q_step = (r_q >= BCD_MAX) ? 4'd0 : r_q + 4'd1;
        end else begin
            w_q_step = (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
        end
    end

    assign co = ci && (up ? (r_q == BCD_MAX) : (r_q == 4'd0));
    assign q  = r_q;

    // Digit register: clr beats load beats step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 4'd0;
        end else if (clr) begin
            r_q <= 4'd0;
        end else if (load) begin
            r_q <= bcd_sanitize(load_val);
        end else if (ci) begin
            r_q <= w_q_step;
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit up/down BCD counter with a multiplexed 7-segment scan output.
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic        up,
    output logic [15:0] count,
    output logic        carry,
    output logic [3:0]  digit,
    output logic [3:0]  dsel
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    logic [4:0]  w_ci;
    logic [3:0]  w_co;
    logic        r_carry;
    logic [15:0] r_presc;
    logic [1:0]  r_scan;
    logic [3:0]  r_dsel;
    logic        w_presc_wrap;
    logic [1:0]  w_scan_next;

    // Ripple chain: en feeds the units cell, each co enables the next decade.
    assign w_ci[0] = en;

    for (genvar k = 0; k < 4; k++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .load     (load),
            .load_val (load_val[4*k +: 4]),
            .ci       (w_ci[k]),
            .up       (up),
            .q        (count[4*k +: 4]),
            .co       (w_co[k])
        );
        assign w_ci[k+1] = w_co[k];
    end

    // Wrap pulse: thousands rollover, suppressed when clr or load takes the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= w_co[3] && !clr && !load;
        end
    end

    assign w_presc_wrap = (r_presc >= PRESC_LAST);
    assign w_scan_next  = r_scan + 2'd1;

    // Free-running prescaler; scan index and its one-hot select move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 16'd0;
            r_scan  <= 2'd0;
            r_dsel  <= DSEL_D0;
        end else if (w_presc_wrap) begin
            r_presc <= 16'd0;
            r_scan  <= w_scan_next;
            r_dsel  <= dsel_onehot(w_scan_next);
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Digit mux reads registered count and index, so it can never skew from dsel.
    always_comb begin
        digit = 4'd0;
        unique case (r_scan)
            2'd0:    digit = count[3:0];
            2'd1:    digit = count[7:4];
            2'd2:    digit = count[11:8];
            default: digit = count[15:12];
        endcase
    end

    assign carry = r_carry;
    assign dsel  = r_dsel;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench: decimal-integer model compared every cycle, plus
// hand-computed directed vectors.
module tb_bcd_scan_counter;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  digit;
    logic [3:0]  dsel;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    bit chk_on   = 0;

    bcd_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .count    (count),
        .carry    (carry),
        .digit    (digit),
        .dsel     (dsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int load_value(input logic [15:0] lv);
        int r = 0;
        int w = 1;
        logic [15:0] t = lv;
        for (int i = 0; i < 4; i++) begin
            if (t[3:0] <= 4'd9) r += w * int'(t[3:0]);
            t = t >> 4;
            w = w * 10;
        end
        return r;
    endfunction

    // Model: count as a plain integer 0..9999, edges since reset for the scan.
    int m_val;
    bit m_carry;
    int m_ticks;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val   <= 0;
            m_carry <= 0;
            m_ticks <= 0;
        end else begin
            m_ticks <= m_ticks + 1;
            if (clr) begin
                m_val   <= 0;
                m_carry <= 0;
            end else if (load) begin
                m_val   <= load_value(load_val);
                m_carry <= 0;
            end else if (en && up) begin
                m_val   <= (m_val + 1) % 10000;
                m_carry <= (m_val == 9999);
            end else if (en) begin
                m_val   <= (m_val + 9999) % 10000;
                m_carry <= (m_val == 0);
            end else begin
                m_carry <= 0;
            end
        end
    end

    logic [15:0] mdl_bcd;
    int          mdl_idx;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            mdl_bcd = to_bcd(m_val);
            mdl_idx = (m_ticks / SCAN_DIV) % 4;
            check("model_count", count, mdl_bcd);
            check("model_carry", 16'(carry), 16'(m_carry));
            check("model_dsel", 16'(dsel), 16'(1 << mdl_idx));
            check("model_digit", 16'(digit), (mdl_bcd >> (4 * mdl_idx)) & 16'hf);
        end
        if (carry) pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pat[4];
        pat = '{4, 3, 2, 1};
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 16'h0; en = 1'b0; up = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_count", count, 16'h0000);
        check("rst_carry", 16'(carry), 16'h0);
        check("rst_dsel", 16'(dsel), 16'h0001);
        check("rst_digit", 16'(digit), 16'h0);

        // Full up-count from reset through the 9999 -> 0000 wrap.
        rst_n = 1'b1; en = 1'b1; up = 1'b1; pulses = 0;
        repeat (9999) @(negedge clk);
        check("up_9999", count, 16'h9999);
        check("up_9999_carry", 16'(carry), 16'h0);
        @(negedge clk);
        check("up_wrap", count, 16'h0000);
        check("up_wrap_carry", 16'(carry), 16'h1);
        en = 1'b0;
        @(negedge clk);
        #1;
        check("up_wrap_after", 16'(carry), 16'h0);
        check("up_pulse_count", 16'(pulses), 16'h1);

        // Down-count with borrow ripple.
        @(negedge clk);
        load = 1'b1; load_val = 16'h0100;
        @(negedge clk);
        check("load_0100", count, 16'h0100);
        load = 1'b0; en = 1'b1; up = 1'b0;
        @(negedge clk);
        check("down_0099", count, 16'h0099);
        check("down_0099_carry", 16'(carry), 16'h0);
        @(negedge clk);
        check("down_0098", count, 16'h0098);
        check("down_0098_carry", 16'(carry), 16'h0);
        en = 1'b0;

        // Sanitised load, then clr over load.
        load = 1'b1; load_val = 16'hA5F3;
        @(negedge clk);
        check("load_A5F3", count, 16'h0503);
        clr = 1'b1;
        @(negedge clk);
        check("clr_over_load", count, 16'h0000);
        clr = 1'b0; load = 1'b0;

        // Down-wrap 0000 -> 9999 with carry, then hold.
        en = 1'b1; up = 1'b0;
        @(negedge clk);
        check("down_wrap", count, 16'h9999);
        check("down_wrap_carry", 16'(carry), 16'h1);
        en = 1'b0;
        @(negedge clk);
        check("hold", count, 16'h9999);
        check("hold_carry", 16'(carry), 16'h0);

        // clr preempting an up-wrap, load preempting a down-wrap.
        en = 1'b1; up = 1'b1; clr = 1'b1;
        @(negedge clk);
        check("clr_preempt", count, 16'h0000);
        check("clr_preempt_carry", 16'(carry), 16'h0);
        clr = 1'b0; up = 1'b0; load = 1'b1; load_val = 16'h1234;
        @(negedge clk);
        check("load_preempt", count, 16'h1234);
        check("load_preempt_carry", 16'(carry), 16'h0);
        load = 1'b0; en = 1'b0;

        // Scan pattern over one full 16-cycle frame.
        for (int i = 0; i < 16 && (m_ticks % 16) != 0; i++) @(negedge clk);
        check("scan_align", 16'(m_ticks % 16), 16'h0);
        for (int j = 0; j < 16; j++) begin
            check("scan_dsel", 16'(dsel), 16'(1 << (j / 4)));
            check("scan_digit", 16'(digit), 16'(pat[j / 4]));
            @(negedge clk);
        end

        // Asynchronous reset between edges, just before a wrap.
        load = 1'b1; load_val = 16'h9998;
        @(negedge clk);
        load = 1'b0; en = 1'b1; up = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        en = 1'b0;
        check("async_count", count, 16'h0000);
        check("async_carry", 16'(carry), 16'h0);
        check("async_dsel", 16'(dsel), 16'h0001);
        check("async_digit", 16'(digit), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_carry", 16'(carry), 16'h0);
        check("post_rst_count", count, 16'h0000);

        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per digit-scan slot; legal range 1..65535.
REQ-002 Port clk  input  1  rising-edge clock; single clock domain.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port clr  input  1  synchronous clear of all four digits.
REQ-005 Port load  input  1  synchronous load of load_val.
REQ-006 Port load_val  input  16  four BCD digits; [3:0] is units, [15:12] is thousands.
REQ-007 Port en  input  1  count enable; one step per cycle while high.
REQ-008 Port up  input  1  direction: 1 counts up, 0 counts down.
REQ-009 Port count  output  16  registered four-digit BCD value, same digit ordering as load_val.
REQ-010 Port carry  output  1  one-cycle wrap pulse.
REQ-011 Port digit  output  4  BCD digit currently scanned; feeds the 7-segment decoder input.
REQ-012 Port dsel  output  4  one-hot, active-high select; bit k marks digit k.

Function
REQ-013 Command priority each cycle SHALL be clr > load > en; when en=0 and no command is active, count holds.
REQ-014 clr SHALL set count to 16'h0000 on the next edge.
REQ-015 load SHALL set count to load_val on the next edge, with every nibble greater than 9 replaced by 0.
REQ-016 en=1, up=1 SHALL increment count by one in decimal, with carry rippling in the same cycle (0099 -> 0100).
REQ-017 en=1, up=0 SHALL decrement count by one in decimal, with borrow rippling in the same cycle (0100 -> 0099).
REQ-018 Up-wrap 9999 -> 0000 and down-wrap 0000 -> 9999 SHALL each assert carry for exactly the one cycle after the wrapping edge.
REQ-019 carry SHALL be 0 in every other cycle, including cycles in which clr or load preempts a wrap.
REQ-020 Each digit of count SHALL remain in 0..9 at all times.
REQ-021 A prescaler SHALL count 0..SCAN_DIV-1 continuously and independently of en, clr and load.
REQ-022 Each prescaler wrap SHALL advance the scan index 0 -> 1 -> 2 -> 3 -> 0.
REQ-023 With SCAN_DIV=1, the scan index SHALL advance every cycle.
REQ-024 dsel SHALL be registered and equal to the one-hot encoding of the scan index.
REQ-025 digit SHALL equal the count nibble selected by the scan index, using the count value after the current edge.
REQ-026 The digit/dsel pair SHALL never be skewed by a cycle, so the display never shows a mismatched digit.

Reset
REQ-027 While rst_n=0: count=0000, carry=0, prescaler=0, scan index=0, dsel=4'b0001, digit=4'h0, independent of clk.
REQ-028 A reset asserted mid-count or mid-scan SHALL take effect immediately.
REQ-029 The first count step after reset SHALL occur on the first rising edge with rst_n=1 and en=1.

Structure
REQ-030 The shared package SHALL hold BCD_MAX=4'd9, the SCAN_DIV default, and the dsel one-hot constants.
REQ-031 The single decade cell SHALL be sub-module bcd_digit, with ports ci, up, q and co.
REQ-032 bcd_scan_counter SHALL instantiate bcd_digit four times in a ripple chain.
REQ-033 The design SHALL contain no latches and no derived or gated clocks.

Verification
REQ-034 Reset, then en=1, up=1 for 10000 cycles -> count reaches 9999, then 0000; carry=1 for exactly one cycle, at the wrap.
REQ-035 Load 16'h0100, then en=1, up=0 for 2 cycles -> count 0099, then 0098; carry stays 0.
REQ-036 load=1 with load_val=16'hA5F3 -> count=16'h0503; same cycle with clr=1 -> count=0000.
REQ-037 SCAN_DIV=4, count=16'h1234 -> over 16 cycles (dsel,digit) = (0001,4), (0010,3), (0100,2), (1000,1), each held 4 cycles.
REQ-038 rst_n pulsed low between clock edges mid-count -> outputs reach their reset values before the next edge, and carry stays 0.
